// File: rtl/alternador_pkg.sv
// Shared definitions for the duplex pump scheduler (alternador_bombas).
// Holds the FSM state encoding, the pump index constants and a helper
// that turns a pump index into its one-hot run command.
package alternador_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    MARCHA   = 2'd1,
    DESCANSO = 2'd2,
    FALLA    = 2'd3
  } estado_t;

  localparam logic BOMBA_A = 1'b0;
  localparam logic BOMBA_B = 1'b1;

  function automatic logic [1:0] un_caliente(input logic idx);
    return (idx == BOMBA_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alternador_bombas_temporizador_carga.sv
// temporizador_carga: loadable down-counter, saturating at zero.
// Used by the pump scheduler for both the minimum run time and the
// minimum rest time.
// Ports:
//   ck       clock, rising edge
//   rst_i    asynchronous active-low reset (count clears to 0)
//   carga_i  load valor_i on this edge (takes precedence over counting)
//   valor_i  value to load
//   cero_o   count is zero (decoded from the register)
module temporizador_carga #(
  parameter int unsigned TMR_W = 16
) (
  input  logic             ck,
  input  logic             rst_i,
  input  logic             carga_i,
  input  logic [TMR_W-1:0] valor_i,
  output logic             cero_o
);

  logic [TMR_W-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (carga_i) begin
      cuenta_d = valor_i;
    end else if (cuenta_q != '0) begin
      cuenta_d = cuenta_q - 1'b1;
    end
  end

  always_ff @(posedge ck or negedge rst_i) begin
    if (!rst_i) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign cero_o = (cuenta_q == '0);

endmodule

// File: rtl/alternador_bombas.sv
// alternador_bombas: duplex pump scheduler between the tank level
// controller and the two pump contactor drivers. Alternates the lead pump
// on every normal stop, enforces minimum run/rest times, fails over to the
// standby pump on overload and latches faults until acknowledged.
// Ports:
//   ck           clock, rising edge
//   rst_i        asynchronous active-low reset
//   demanda_i    fill request
//   falla_i[1:0] per-pump overload/thermal fault, active high
//   ack_i        operator fault acknowledge pulse
//   bomba_o[1:0] pump run commands (one-hot or zero)
//   alarma_o     any latched fault set (or waiting in FALLA)
//   lider_o      current lead pump index
//   arranques_o  per-pump saturating start counters, pump n at
//                [n*CNT_W +: CNT_W]; present only with ALTERNADOR_CONTEO_EN
module alternador_bombas
  import alternador_pkg::*;
#(
  parameter int unsigned T_MIN_ON  = 1000,
  parameter int unsigned T_MIN_OFF = 500,
  parameter int unsigned TMR_W     = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               ck,
  input  logic               rst_i,
  input  logic               demanda_i,
  input  logic [1:0]         falla_i,
  input  logic               ack_i,
  output logic [1:0]         bomba_o,
  output logic               alarma_o,
  output logic               lider_o
`ifdef ALTERNADOR_CONTEO_EN
  ,
  output logic [2*CNT_W-1:0] arranques_o
`endif
);

  if (T_MIN_ON < 1 || T_MIN_OFF < 1 || CNT_W < 1 ||
      ((T_MIN_ON - 1) >> TMR_W) != 0 || ((T_MIN_OFF - 1) >> TMR_W) != 0) begin : g_param_invalido
    $error("alternador_bombas: invalid timing/width parameters");
  end

  localparam logic [TMR_W-1:0] CARGA_ON  = TMR_W'(T_MIN_ON - 1);
  localparam logic [TMR_W-1:0] CARGA_OFF = TMR_W'(T_MIN_OFF - 1);

  estado_t          estado_q, estado_d;
  logic             sel_q, sel_d;
  logic             lider_q, lider_d;
  logic [1:0]       falla_q, falla_d;
  logic [1:0]       sano;
  logic             carga;
  logic [TMR_W-1:0] carga_val;
  logic             cero;

  // Set has priority: a bit only clears when ack arrives with its fault input low.
  assign falla_d = falla_i | (falla_q & ~({2{ack_i}} & ~falla_i));
  assign sano    = ~(falla_q | falla_i);

  temporizador_carga #(
    .TMR_W (TMR_W)
  ) u_tmr (
    .ck      (ck),
    .rst_i   (rst_i),
    .carga_i (carga),
    .valor_i (carga_val),
    .cero_o  (cero)
  );

  always_ff @(posedge ck or negedge rst_i) begin
    if (!rst_i) begin
      estado_q <= REPOSO;
      sel_q    <= BOMBA_A;
      lider_q  <= BOMBA_A;
      falla_q  <= '0;
    end else begin
      estado_q <= estado_d;
      sel_q    <= sel_d;
      lider_q  <= lider_d;
      falla_q  <= falla_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    sel_d     = sel_q;
    lider_d   = lider_q;
    carga     = 1'b0;
    carga_val = CARGA_ON;
    case (estado_q)
      REPOSO: begin
        if (demanda_i) begin
          if (sano[lider_q]) begin
            sel_d    = lider_q;
            estado_d = MARCHA;
            carga    = 1'b1;
          end else if (sano[~lider_q]) begin
            sel_d    = ~lider_q;
            estado_d = MARCHA;
            carga    = 1'b1;
          end else begin
            estado_d = FALLA;
          end
        end
      end
      MARCHA: begin
        if (falla_i[sel_q]) begin
          if (sano[~sel_q]) begin
            if (demanda_i) begin
              // Swap in a single edge: the decoded command moves with sel.
              sel_d = ~sel_q;
              carga = 1'b1;
            end else begin
              estado_d  = DESCANSO;
              carga     = 1'b1;
              carga_val = CARGA_OFF;
            end
          end else begin
            estado_d = FALLA;
          end
        end else if (!demanda_i && cero) begin
          estado_d  = DESCANSO;
          lider_d   = ~sel_q;
          carga     = 1'b1;
          carga_val = CARGA_OFF;
        end
      end
      DESCANSO: begin
        if (cero) begin
          estado_d = REPOSO;
        end
      end
      FALLA: begin
        if (|sano) begin
          estado_d = REPOSO;
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  always_comb begin
    bomba_o  = (estado_q == MARCHA) ? un_caliente(sel_q) : 2'b00;
    alarma_o = (|falla_q) || (estado_q == FALLA);
    lider_o  = lider_q;
  end

`ifdef ALTERNADOR_CONTEO_EN
  logic [1:0][CNT_W-1:0] arranques_q, arranques_d;
  logic                  arranque;

  assign arranque = ((estado_q == REPOSO) && (estado_d == MARCHA)) ||
                    ((estado_q == MARCHA) && (estado_d == MARCHA) && (sel_d != sel_q));

  always_comb begin
    arranques_d = arranques_q;
    if (arranque && (arranques_q[sel_d] != '1)) begin
      arranques_d[sel_d] = arranques_q[sel_d] + 1'b1;
    end
  end

  always_ff @(posedge ck or negedge rst_i) begin
    if (!rst_i) begin
      arranques_q <= '0;
    end else begin
      arranques_q <= arranques_d;
    end
  end

  assign arranques_o = arranques_q;
`endif

endmodule

// File: tb/tb_alternador_bombas.sv
// Bench for alternador_bombas with T_MIN_ON=4, T_MIN_OFF=3: directed
// scenarios followed by random demand/fault/ack traffic, each cycle compared
// against a behavioural model that tracks elapsed run and rest time.
module tb_alternador_bombas;

  localparam int T_ON  = 4;
  localparam int T_OFF = 3;

  logic       ck = 1'b0;
  logic       rst_i;
  logic       demanda_i;
  logic [1:0] falla_i;
  logic       ack_i;
  logic [1:0] bomba_o;
  logic       alarma_o;
  logic       lider_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [1:0] m_fq;
  logic       m_lead;
  logic       m_run;
  logic       m_pump;
  int         m_cnt;
  logic       m_rest;
  int         m_rcnt;
  logic       m_fw;

  always #5 ck = ~ck;

  alternador_bombas #(
    .T_MIN_ON  (T_ON),
    .T_MIN_OFF (T_OFF),
    .TMR_W     (16),
    .CNT_W     (16)
  ) dut (
    .ck        (ck),
    .rst_i     (rst_i),
    .demanda_i (demanda_i),
    .falla_i   (falla_i),
    .ack_i     (ack_i),
    .bomba_o   (bomba_o),
    .alarma_o  (alarma_o),
    .lider_o   (lider_o)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fq = 2'b00; m_lead = 1'b0; m_run = 1'b0; m_pump = 1'b0;
    m_cnt = 0; m_rest = 1'b0; m_rcnt = 0; m_fw = 1'b0;
  endtask

  task automatic model_step(input logic d, input logic [1:0] f, input logic a);
    logic [1:0] ok;
    ok = ~(m_fq | f);
    if (m_run) begin
      m_cnt++;
      if (f[m_pump]) begin
        if (ok[!m_pump]) begin
          if (d) begin
            m_pump = !m_pump;
            m_cnt  = 0;
          end else begin
            m_run = 1'b0; m_rest = 1'b1; m_rcnt = 0;
          end
        end else begin
          m_run = 1'b0; m_fw = 1'b1;
        end
      end else if (!d && m_cnt >= T_ON) begin
        m_run = 1'b0; m_rest = 1'b1; m_rcnt = 0;
        m_lead = !m_pump;
      end
    end else if (m_rest) begin
      m_rcnt++;
      if (m_rcnt >= T_OFF) m_rest = 1'b0;
    end else if (m_fw) begin
      if (ok != 2'b00) m_fw = 1'b0;
    end else if (d) begin
      if (ok[m_lead]) begin
        m_run = 1'b1; m_pump = m_lead; m_cnt = 0;
      end else if (ok[!m_lead]) begin
        m_run = 1'b1; m_pump = !m_lead; m_cnt = 0;
      end else begin
        m_fw = 1'b1;
      end
    end
    for (int n = 0; n < 2; n++) begin
      if (f[n]) m_fq[n] = 1'b1;
      else if (a) m_fq[n] = 1'b0;
    end
  endtask

  task automatic chk_model();
    logic [1:0] eb;
    eb = m_run ? 2'(1 << m_pump) : 2'b00;
    chk("bomba", {6'b0, bomba_o}, {6'b0, eb});
    chk("alarma", {7'b0, alarma_o}, {7'b0, ((m_fq != 2'b00) || m_fw)});
    chk("lider", {7'b0, lider_o}, {7'b0, m_lead});
  endtask

  task automatic tick(input logic d, input logic [1:0] f, input logic a);
    demanda_i = d; falla_i = f; ack_i = a;
    @(posedge ck);
    model_step(d, f, a);
    #1;
    chk_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic d;
    logic [1:0] f;
    logic a;

    rst_i = 1'b0; demanda_i = 1'b0; falla_i = 2'b00; ack_i = 1'b0;
    model_reset();
    repeat (2) @(posedge ck);
    #1;
    chk("reset_bomba", {6'b0, bomba_o}, 8'h00);
    chk("reset_alarma", {7'b0, alarma_o}, 8'h00);
    chk("reset_lider", {7'b0, lider_o}, 8'h00);
    @(negedge ck);
    rst_i = 1'b1;

    // Single-cycle demand: pump 0 runs exactly T_ON cycles.
    n = 0;
    tick(1'b1, 2'b00, 1'b0);
    if (bomba_o == 2'b01) n++;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 2'b00, 1'b0);
      if (bomba_o == 2'b01) n++;
    end
    chk("run_len_p0", 8'(n), 8'(T_ON));
    chk("lider_after_stop", {7'b0, lider_o}, 8'h01);

    // Demand immediately after the stop: off for T_OFF+1 cycles, then pump 1.
    n = 1;
    for (int i = 0; i < 20 && bomba_o == 2'b00; i++) begin
      tick(1'b1, 2'b00, 1'b0);
      if (bomba_o == 2'b00) n++;
    end
    chk("min_off", 8'(n), 8'(T_OFF + 1));
    chk("second_run_p1", {6'b0, bomba_o}, 8'h02);
    for (int i = 0; i < 12; i++) tick(1'b0, 2'b00, 1'b0);
    chk("lider_back_0", {7'b0, lider_o}, 8'h00);

    // Failover while demand held.
    tick(1'b1, 2'b00, 1'b0);
    tick(1'b1, 2'b00, 1'b0);
    tick(1'b1, 2'b01, 1'b0);
    chk("swap_bomba", {6'b0, bomba_o}, 8'h02);
    chk("swap_alarma", {7'b0, alarma_o}, 8'h01);
    chk("swap_lider", {7'b0, lider_o}, 8'h00);
    n = 1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 2'b00, 1'b0);
      if (bomba_o == 2'b10) n++;
    end
    chk("swap_run_len", 8'(n), 8'(T_ON));
    tick(1'b0, 2'b00, 1'b1);
    chk("ack_clears", {7'b0, alarma_o}, 8'h00);
    for (int i = 0; i < 6; i++) tick(1'b0, 2'b00, 1'b0);

    // Both pumps fault while running, then recover pump 1.
    tick(1'b1, 2'b00, 1'b0);
    tick(1'b1, 2'b11, 1'b0);
    chk("dual_fault_off", {6'b0, bomba_o}, 8'h00);
    tick(1'b1, 2'b01, 1'b1);
    chk("alarma_held_p0", {7'b0, alarma_o}, 8'h01);
    n = 0;
    for (int i = 0; i < 6 && bomba_o != 2'b10; i++) begin
      tick(1'b1, 2'b01, 1'b0);
      n++;
    end
    chk("recover_latency", 8'(n), 8'd2);
    chk("recover_bomba", {6'b0, bomba_o}, 8'h02);

    // Ack coinciding with an active fault: set wins.
    tick(1'b1, 2'b01, 1'b1);
    chk("set_wins", {7'b0, alarma_o}, 8'h01);
    tick(1'b0, 2'b00, 1'b1);
    chk("clear_after", {7'b0, alarma_o}, 8'h00);
    for (int i = 0; i < 12; i++) tick(1'b0, 2'b00, 1'b0);

    // Asynchronous reset mid-run.
    tick(1'b1, 2'b00, 1'b0);
    chk("pre_reset_run", {6'b0, bomba_o}, 8'h01);
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    chk("async_bomba", {6'b0, bomba_o}, 8'h00);
    chk("async_lider", {7'b0, lider_o}, 8'h00);
    @(negedge ck);
    demanda_i = 1'b0;
    rst_i = 1'b1;

    // Random traffic against the model.
    d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) d = ~d;
      f = 2'b00;
      if ($urandom_range(0, 40) == 0) f[0] = 1'b1;
      if ($urandom_range(0, 40) == 0) f[1] = 1'b1;
      a = ($urandom_range(0, 9) == 0);
      tick(d, f, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
